cpu_step_ctrl: RTL

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module   : cpu_step_ctrl
// Brief    : Run / single-step / halt control for a CPU pipeline. Produces a
//            one-cycle cpu_en pulse on each rising edge of a selectable
//            clk_div_counter tap while running, or exactly once per
//            step_req rising edge while halted.
// Options  : define STEP_COUNT_EN to add cnt_clr / step_count, a wrapping
//            count of issued cpu_en pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      clk_div_counter,
  input  logic [4:0]       tap_sel,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
`ifdef STEP_COUNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] step_count,
`endif
  output logic             cpu_en,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   tap;
  logic   tap_q;
  logic   tick;
  logic   step_q;
  logic   step_rise;
  logic   cpu_en_nxt;

  // A tap_sel change compares the newly selected bit against the old stored
  // tap, so it can cause at most one spurious tick; that is accepted.
  assign tap       = clk_div_counter[tap_sel];
  assign tick      = tap & ~tap_q;
  assign step_rise = step_req & ~step_q;
  assign state     = cur_state;

  // State register, edge-detect history and the registered cpu_en pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= HALT;
      tap_q     <= 1'b0;
      step_q    <= 1'b0;
      cpu_en    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      tap_q     <= tap;
      step_q    <= step_req;
      cpu_en    <= cpu_en_nxt;
    end
  end

  // Next-state and pulse decision; halt_req overrides everything.
  always_comb begin
    nxt_state  = cur_state;
    cpu_en_nxt = 1'b0;
    case (cur_state)
      HALT: begin
        if (halt_req) begin
          nxt_state = HALT;
        end else if (run_req) begin
          nxt_state = RUN;        // a simultaneous step request is dropped
        end else if (step_rise) begin
          nxt_state = STEP;
        end
      end
      RUN: begin
        if (halt_req || !run_req) begin
          nxt_state = HALT;       // a tick in this cycle is discarded
        end else begin
          cpu_en_nxt = tick;
        end
      end
      STEP: begin
        if (halt_req) begin
          nxt_state = HALT;       // abort without issuing the step
        end else if (tick) begin
          nxt_state  = HALT;
          cpu_en_nxt = 1'b1;
        end
      end
      default: begin
        nxt_state = HALT;
      end
    endcase
  end

`ifdef STEP_COUNT_EN
  // Count issued pulses one cycle behind cpu_en; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      step_count <= '0;
    end else if (cpu_en) begin
      step_count <= step_count + 1'b1;
    end
  end
`else
  // Without the counter CNT_W only needs to be a legal width.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("cpu_step_ctrl: CNT_W must be at least 1");
  end
`endif

endmodule

`default_nettype wire
